// File: rtl/mem_io_bridge.sv
// Memory-mapped bridge from the CPU Req/Ack bus to external SRAM and a bank of
// synchronised input channels / output registers in a 16-word I/O window.
module mem_io_bridge #(
  parameter int          DATA_W    = 16,
  parameter int          ADDR_W    = 20,
  parameter int          NUM_IN    = 1,
  parameter int          NUM_OUT   = 4,
  parameter logic [15:0] IO_BASE   = 16'hFFF0,
  parameter int          SRAM_WAIT = 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Req,
  input  logic                      WE,
  input  logic [ADDR_W-1:0]         ADDR,
  input  logic [DATA_W-1:0]         Data_from_CPU,
  output logic [DATA_W-1:0]         Data_to_CPU,
  output logic                      Ack,
  output logic [ADDR_W-1:0]         SRAM_ADDR,
  output logic [DATA_W-1:0]         Data_to_SRAM,
  input  logic [DATA_W-1:0]         Data_from_SRAM,
  output logic                      SRAM_CE_N,
  output logic                      SRAM_OE_N,
  output logic                      SRAM_WE_N,
  input  logic [NUM_IN*DATA_W-1:0]  In_ch,
  output logic [NUM_OUT*DATA_W-1:0] Out_ch,
  output logic [NUM_OUT-1:0]        Out_stb
);

  typedef enum logic [1:0] {IDLE, IO, SRAM, ACK} state_t;

  state_t state, next_state;

  logic                     io_hit;
  logic [NUM_IN*DATA_W-1:0] sync1, sync2;
  logic                     we_q;
  logic [3:0]               idx_q;
  logic [DATA_W-1:0]        wdata_q;
  logic [3:0]               wait_cnt;
  logic [DATA_W-1:0]        io_rdata;

  assign io_hit = (ADDR[15:4] == IO_BASE[15:4]);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= In_ch;
      sync2 <= sync1;
    end
  end

  // Unpopulated input slots read back as zero.
  always_comb begin
    io_rdata = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (idx_q == 4'(i)) io_rdata = sync2[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    Ack        = 1'b0;
    case (state)
      IDLE: if (Req) next_state = io_hit ? IO : SRAM;
      IO:   next_state = ACK;
      SRAM: if (!SRAM_CE_N && wait_cnt == 4'd0) next_state = ACK;
      ACK: begin
        Ack        = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The first SRAM cycle only presents address/data; strobes assert on the
  // following edge so the address is settled before CE_N falls.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      we_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      wait_cnt     <= '0;
      Data_to_CPU  <= '0;
      SRAM_ADDR    <= '0;
      Data_to_SRAM <= '0;
      SRAM_CE_N    <= 1'b1;
      SRAM_OE_N    <= 1'b1;
      SRAM_WE_N    <= 1'b1;
      Out_ch       <= '0;
      Out_stb      <= '0;
    end else begin
      Out_stb <= '0;
      case (state)
        IDLE: begin
          if (Req) begin
            we_q    <= WE;
            idx_q   <= ADDR[3:0];
            wdata_q <= Data_from_CPU;
            if (!io_hit) begin
              SRAM_ADDR    <= ADDR;
              Data_to_SRAM <= Data_from_CPU;
              wait_cnt     <= 4'(SRAM_WAIT);
            end
          end
        end
        IO: begin
          if (we_q) begin
            for (int i = 0; i < NUM_OUT; i++) begin
              if (idx_q == 4'(i)) begin
                Out_ch[i*DATA_W +: DATA_W] <= wdata_q;
                Out_stb[i]                 <= 1'b1;
              end
            end
          end else begin
            Data_to_CPU <= io_rdata;
          end
        end
        SRAM: begin
          if (SRAM_CE_N) begin
            SRAM_CE_N <= 1'b0;
            SRAM_OE_N <= we_q;
            SRAM_WE_N <= !we_q;
          end else if (wait_cnt == 4'd0) begin
            if (!we_q) Data_to_CPU <= Data_from_SRAM;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
